// File: rtl/duck_pkg.sv
// Shared types for the duck-hunt game blocks: game states, per-gun shot states
// and a saturating counter helper.
package duck_pkg;

    typedef enum logic [1:0] {
        GS_MENU      = 2'd0,
        GS_PLAY      = 2'd1,
        GS_ROUND_END = 2'd2,
        GS_OVER      = 2'd3
    } game_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        COOL  = 2'd2,
        EMPTY = 2'd3
    } shot_state_t;

    // Widest counter field needed for MAX_SHOTS up to 15.
    localparam int CNT_MAX_W = 4;

    function automatic logic [CNT_MAX_W-1:0] sat_inc(
        input logic [CNT_MAX_W-1:0] val,
        input logic [CNT_MAX_W-1:0] lim
    );
        if (val >= lim) begin
            return lim;
        end else begin
            return val + 4'd1;
        end
    endfunction

endpackage

// File: rtl/shot_channel.sv
// One gun: trigger synchroniser, rising-edge detect, shot FSM, cooldown and
// optional hit window (compiled in when SHOT_TRACKER_HIT_STATS_EN is defined).
module shot_channel
    import duck_pkg::*;
#(
    parameter int MAX_SHOTS    = 3,
    parameter int COOLDOWN_CYC = 4,
    parameter int HIT_WINDOW   = 8,
    parameter int CNT_W        = $clog2(MAX_SHOTS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_play,
    input  logic             play_entry,
    input  logic             trigger,
    input  logic             hit,
    output logic             shot_fire,
    output logic [CNT_W-1:0] shots_left,
    output logic             no_shots_left,
    output logic [CNT_W-1:0] hit_count
);

    localparam int              CD_W    = $clog2(COOLDOWN_CYC + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_SHOTS);
    localparam logic [CD_W-1:0]  CD_LOAD = CD_W'(COOLDOWN_CYC);

    logic             sync1_r, sync2_r, sync2_d_r, rise_r;
    shot_state_t      state_r, state_s;
    logic [CD_W-1:0]  cool_r, cool_s;
    logic [CNT_W-1:0] shots_r, shots_s;
    logic             fire_r, fire_s;
    logic             empty_r;
    logic             accept_s;

    // Trigger synchroniser and registered rising-edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r   <= 1'b0;
            sync2_r   <= 1'b0;
            sync2_d_r <= 1'b0;
            rise_r    <= 1'b0;
        end else begin
            sync1_r   <= trigger;
            sync2_r   <= sync1_r;
            sync2_d_r <= sync2_r;
            rise_r    <= sync2_r & ~sync2_d_r;
        end
    end

    // Next-state logic: reload beats everything, leaving PLAY parks the channel.
    always_comb begin
        state_s  = state_r;
        cool_s   = cool_r;
        shots_s  = shots_r;
        fire_s   = 1'b0;
        accept_s = 1'b0;
        if (play_entry) begin
            state_s = ARMED;
            cool_s  = '0;
            shots_s = MAX_CNT;
        end else if (!in_play) begin
            state_s = IDLE;
            cool_s  = '0;
        end else begin
            case (state_r)
                ARMED: begin
                    if (rise_r) begin
                        accept_s = 1'b1;
                        fire_s   = 1'b1;
                        shots_s  = shots_r - CNT_W'(1);
                        cool_s   = CD_LOAD;
                        state_s  = COOL;
                    end else begin
                        state_s  = ARMED;
                    end
                end
                COOL: begin
                    // Leave on the edge where the counter lands on zero.
                    if (cool_r <= CD_W'(1)) begin
                        cool_s  = '0;
                        state_s = (shots_r != '0) ? ARMED : EMPTY;
                    end else begin
                        cool_s  = cool_r - CD_W'(1);
                        state_s = COOL;
                    end
                end
                EMPTY:   state_s = EMPTY;
                IDLE:    state_s = IDLE;
                default: state_s = IDLE;
            endcase
        end
    end

    // Channel state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cool_r  <= '0;
            shots_r <= '0;
            fire_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            state_r <= state_s;
            cool_r  <= cool_s;
            shots_r <= shots_s;
            fire_r  <= fire_s;
            empty_r <= (shots_s == '0);
        end
    end

    assign shot_fire     = fire_r;
    assign shots_left    = shots_r;
    assign no_shots_left = empty_r;

`ifdef SHOT_TRACKER_HIT_STATS_EN
    localparam int              WIN_W    = $clog2(HIT_WINDOW + 1);
    localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(HIT_WINDOW);

    logic [WIN_W-1:0] win_r, win_s;
    logic             win_arm_r, win_arm_s;
    logic [CNT_W-1:0] hits_r, hits_s;

    // The new window opens one cycle after acceptance, so a hit in the
    // shot_fire cycle still lands in the previous window.
    always_comb begin
        win_s     = win_r;
        win_arm_s = 1'b0;
        hits_s    = hits_r;
        if (play_entry) begin
            win_s  = '0;
            hits_s = '0;
        end else if (!in_play) begin
            win_s  = '0;
        end else begin
            win_arm_s = accept_s;
            if (hit && (win_r != '0)) begin
                hits_s = CNT_W'(sat_inc(CNT_MAX_W'(hits_r), CNT_MAX_W'(MAX_CNT)));
            end else begin
                hits_s = hits_r;
            end
            if (win_arm_r) begin
                win_s = WIN_LOAD;
            end else if (win_r == '0) begin
                win_s = '0;
            end else if (hit) begin
                win_s = '0;
            end else begin
                win_s = win_r - WIN_W'(1);
            end
        end
    end

    // Hit window and hit counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_r     <= '0;
            win_arm_r <= 1'b0;
            hits_r    <= '0;
        end else begin
            win_r     <= win_s;
            win_arm_r <= win_arm_s;
            hits_r    <= hits_s;
        end
    end

    assign hit_count = hits_r;
`else
    localparam int unused_hit_window = HIT_WINDOW;
    logic unused_hit_s;
    assign unused_hit_s = hit;
    assign hit_count    = '0;
`endif

    shot_channel_chk #(.CNT_W(CNT_W)) u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .accept     (accept_s),
        .shots_left (shots_r)
    );

endmodule

// File: rtl/shot_channel_chk.sv
// Property checker for one gun channel: a shot may never be taken with an empty
// budget, since that decrement would wrap the shot counter.
module shot_channel_chk #(
    parameter int CNT_W = 2
) (
    input logic             clk,
    input logic             rst_n,
    input logic             accept,
    input logic [CNT_W-1:0] shots_left
);

    property p_no_wrap;
        @(posedge clk) disable iff (!rst_n) accept |-> (shots_left != '0);
    endproperty

    a_no_wrap: assert property (p_no_wrap)
        else $error("shot_channel: shot accepted with shots_left at zero");

endmodule

// File: rtl/shot_tracker.sv
// Multi-gun shot budget tracker: NUM_CH shot_channel instances sharing one
// PLAY-entry detector. Optional hit statistics: SHOT_TRACKER_HIT_STATS_EN.
module shot_tracker
    import duck_pkg::*;
#(
    parameter int  NUM_CH       = 2,
    parameter int  MAX_SHOTS    = 3,
    parameter int  COOLDOWN_CYC = 4,
    parameter int  HIT_WINDOW   = 8,
    localparam int CNT_W        = $clog2(MAX_SHOTS + 1)
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic [1:0]              game_state,
    input  logic [NUM_CH-1:0]       trigger,
    input  logic [NUM_CH-1:0]       hit,
    output logic [NUM_CH-1:0]       shot_fire,
    output logic [NUM_CH*CNT_W-1:0] shots_left,
    output logic [NUM_CH-1:0]       no_shots_left,
    output logic                    all_empty,
    output logic [NUM_CH*CNT_W-1:0] hit_count
);

    game_state_t gs_s, gs_r;
    logic        in_play_s, play_entry_s;

    assign gs_s = game_state_t'(game_state);

    // Previous game state; MENU at reset so the first PLAY cycle counts as entry.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            gs_r <= GS_MENU;
        end else begin
            gs_r <= gs_s;
        end
    end

    assign in_play_s    = (gs_s == GS_PLAY);
    assign play_entry_s = in_play_s && (gs_r != GS_PLAY);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        shot_channel #(
            .MAX_SHOTS    (MAX_SHOTS),
            .COOLDOWN_CYC (COOLDOWN_CYC),
            .HIT_WINDOW   (HIT_WINDOW),
            .CNT_W        (CNT_W)
        ) u_ch (
            .clk           (Clk),
            .rst_n         (Reset_n),
            .in_play       (in_play_s),
            .play_entry    (play_entry_s),
            .trigger       (trigger[i]),
            .hit           (hit[i]),
            .shot_fire     (shot_fire[i]),
            .shots_left    (shots_left[i*CNT_W +: CNT_W]),
            .no_shots_left (no_shots_left[i]),
            .hit_count     (hit_count[i*CNT_W +: CNT_W])
        );
    end

    assign all_empty = &no_shots_left;

endmodule

// File: tb/tb_shot_tracker.sv
// Bench for shot_tracker: directed stimulus, a cycle-level rule model checked
// every cycle, plus literal expectations at key points.
module tb_shot_tracker;

    localparam int NCH = 2;
    localparam int MS  = 3;
    localparam int CD  = 4;
    localparam int HW  = 8;
    localparam int CW  = 2;
`ifdef SHOT_TRACKER_HIT_STATS_EN
    localparam int HITS_ON = 1;
`else
    localparam int HITS_ON = 0;
`endif

    logic              clk        = 1'b0;
    logic              Reset_n    = 1'b0;
    logic [1:0]        game_state = 2'd0;
    logic [NCH-1:0]    trigger    = '0;
    logic [NCH-1:0]    hit        = '0;
    logic [NCH-1:0]    shot_fire;
    logic [NCH*CW-1:0] shots_left;
    logic [NCH-1:0]    no_shots_left;
    logic              all_empty;
    logic [NCH*CW-1:0] hit_count;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    shot_tracker #(
        .NUM_CH(NCH), .MAX_SHOTS(MS), .COOLDOWN_CYC(CD), .HIT_WINDOW(HW)
    ) dut (
        .Clk           (clk),
        .Reset_n       (Reset_n),
        .game_state    (game_state),
        .trigger       (trigger),
        .hit           (hit),
        .shot_fire     (shot_fire),
        .shots_left    (shots_left),
        .no_shots_left (no_shots_left),
        .all_empty     (all_empty),
        .hit_count     (hit_count)
    );

    always #5 clk = ~clk;

    // Model: counts edges since reset and applies the rules on each edge.
    int             cyc;
    logic [NCH-1:0] trig_hist [int];
    logic [1:0]     m_prev_gs;
    int             m_shots [NCH];
    int             m_hits  [NCH];
    int             m_last  [NCH];
    int             m_prev  [NCH];
    bit             m_cur_cred  [NCH];
    bit             m_prev_cred [NCH];
    logic [NCH-1:0] m_fire;

    function automatic bit hist_bit(input int n, input int c);
        if (trig_hist.exists(n)) return trig_hist[n][c];
        return 1'b0;
    endfunction

    task automatic model_reset();
        cyc = 0;
        trig_hist.delete();
        m_prev_gs = 2'd0;
        m_fire = '0;
        for (int c = 0; c < NCH; c++) begin
            m_shots[c] = 0; m_hits[c] = 0;
            m_last[c] = -1000; m_prev[c] = -1000;
            m_cur_cred[c] = 1'b1; m_prev_cred[c] = 1'b1;
        end
    endtask

    task automatic model_step();
        bit play, entry;
        cyc++;
        trig_hist[cyc] = trigger;
        play  = (game_state == 2'd1);
        entry = play && (m_prev_gs != 2'd1);
        m_fire = '0;
        for (int c = 0; c < NCH; c++) begin
            if (entry) begin
                m_shots[c] = MS; m_hits[c] = 0;
                m_last[c] = -1000; m_prev[c] = -1000;
                m_cur_cred[c] = 1'b1; m_prev_cred[c] = 1'b1;
            end else if (!play) begin
                m_last[c] = -1000; m_prev[c] = -1000;
            end else begin
                // A hit belongs to the newest shot whose fire cycle has passed.
                if (HITS_ON != 0 && hit[c]) begin
                    if (m_last[c] <= cyc - 2) begin
                        if (!m_cur_cred[c] && cyc <= m_last[c] + HW + 1) begin
                            m_cur_cred[c] = 1'b1;
                            if (m_hits[c] < MS) m_hits[c]++;
                        end
                    end else if (!m_prev_cred[c] && cyc <= m_prev[c] + HW + 1) begin
                        m_prev_cred[c] = 1'b1;
                        if (m_hits[c] < MS) m_hits[c]++;
                    end
                end
                // Trigger first seen high 3 edges ago after a low sample.
                if (hist_bit(cyc - 3, c) && !hist_bit(cyc - 4, c) &&
                    m_shots[c] > 0 && (cyc - m_last[c]) >= CD + 1) begin
                    m_fire[c] = 1'b1;
                    m_shots[c]--;
                    m_prev[c] = m_last[c];
                    m_prev_cred[c] = m_cur_cred[c];
                    m_last[c] = cyc;
                    m_cur_cred[c] = 1'b0;
                end
            end
        end
        m_prev_gs = game_state;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge Reset_n);
            if (!Reset_n) model_reset();
            else model_step();
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    initial begin
        logic [NCH*CW-1:0] exp_s, exp_h;
        logic [NCH-1:0]    exp_e;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int c = 0; c < NCH; c++) begin
                    exp_s[c*CW +: CW] = CW'(m_shots[c]);
                    exp_h[c*CW +: CW] = CW'(m_hits[c]);
                    exp_e[c] = (m_shots[c] == 0);
                end
                check("cyc_shot_fire", 32'(shot_fire), 32'(m_fire));
                check("cyc_shots_left", 32'(shots_left), 32'(exp_s));
                check("cyc_no_shots_left", 32'(no_shots_left), 32'(exp_e));
                check("cyc_all_empty", 32'(all_empty), 32'(&exp_e));
                check("cyc_hit_count", 32'(hit_count), 32'(exp_h));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single trigger pulse on one channel; returns in the shot_fire cycle.
    task automatic fire_ch(input int c);
        bit seen;
        seen = 1'b0;
        trigger[c] = 1'b1;
        tick();
        trigger[c] = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            tick();
            if (shot_fire[c]) seen = 1'b1;
        end
        check("fire_timeout", 32'(seen), 32'd1);
    endtask

    // Pulse hit k cycles after the current cycle.
    task automatic hit_at(input int c, input int k);
        repeat (k) tick();
        hit[c] = 1'b1;
        tick();
        hit[c] = 1'b0;
    endtask

    task automatic pulses(input int c, input int gap);
        repeat (3) begin
            trigger[c] = 1'b1;
            tick();
            trigger[c] = 1'b0;
            repeat (gap - 1) tick();
        end
        repeat (10) tick();
    endtask

    initial begin
        int first_fire, nfire;
        bit seen;

        tick();
        chk_en = 1'b1;
        tick();
        check("rst_shots_left", 32'(shots_left), 32'd0);
        check("rst_no_shots", 32'(no_shots_left), 32'b11);
        check("rst_all_empty", 32'(all_empty), 32'd1);
        check("rst_shot_fire", 32'(shot_fire), 32'd0);
        check("rst_hit_count", 32'(hit_count), 32'd0);
        Reset_n = 1'b1;
        tick();

        // Enter PLAY: budgets load after one edge.
        game_state = 2'd1;
        tick();
        check("entry_shots_left", 32'(shots_left), 32'hF);
        check("entry_no_shots", 32'(no_shots_left), 32'd0);

        // Held trigger fires once, 3 edges after first sample.
        first_fire = 0; nfire = 0;
        trigger[0] = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (shot_fire[0]) begin
                nfire++;
                if (first_fire == 0) first_fire = i;
            end
        end
        trigger[0] = 1'b0;
        check("held_fire_count", 32'(nfire), 32'd1);
        check("held_fire_latency", 32'(first_fire), 32'd4);
        check("held_shots_left", 32'(shots_left), 32'hE);
        repeat (8) tick();

        // Triggers 2 apart: only the first survives cooldown.
        pulses(0, 2);
        check("cool_shots_ch0", 32'(shots_left[1:0]), 32'd1);
        pulses(0, 6);
        check("drain_shots_ch0", 32'(shots_left[1:0]), 32'd0);
        check("drain_no_shots", 32'(no_shots_left), 32'b01);
        check("drain_all_empty0", 32'(all_empty), 32'd0);
        pulses(1, 6);
        check("drain_shots_all", 32'(shots_left), 32'd0);
        check("drain_all_empty1", 32'(all_empty), 32'd1);

        // Reload, then hit crediting.
        game_state = 2'd2; tick();
        game_state = 2'd1; tick();
        check("reload_shots", 32'(shots_left), 32'hF);
        check("reload_hits", 32'(hit_count), 32'd0);
        fire_ch(0);
        hit_at(0, 5);
        hit_at(0, 1);
        check("hit_once", 32'(hit_count[1:0]), 32'(HITS_ON));
        repeat (4) tick();
        fire_ch(0);
        hit_at(0, 9);
        check("hit_late", 32'(hit_count[1:0]), 32'(HITS_ON));
        repeat (4) tick();
        fire_ch(0);
        hit_at(0, 8);
        check("hit_last_cycle", 32'(hit_count[1:0]), 32'(2 * HITS_ON));
        repeat (4) tick();

        // Simultaneous shots, leave PLAY in COOL, edge on the entry cycle.
        game_state = 2'd2; tick();
        game_state = 2'd1; tick();
        trigger = 2'b11; tick(); trigger = 2'b00;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            tick();
            if (shot_fire == 2'b11) seen = 1'b1;
        end
        check("both_fire", 32'(seen), 32'd1);
        game_state = 2'd2; tick();
        trigger = 2'b11;
        repeat (3) tick();
        game_state = 2'd1;
        tick();
        check("entry_edge_fire", 32'(shot_fire), 32'd0);
        check("entry_edge_shots", 32'(shots_left), 32'hF);
        repeat (6) tick();
        check("entry_edge_nofire", 32'(shots_left), 32'hF);
        trigger = 2'b00;
        repeat (3) tick();

        // Async reset in the middle of a hit window.
        fire_ch(0);
        repeat (5) tick();
        fire_ch(0);
        check("pre_rst_shots", 32'(shots_left[1:0]), 32'd1);
        repeat (2) tick();
        #2 Reset_n = 1'b0;
        #1;
        check("arst_shots_left", 32'(shots_left), 32'd0);
        check("arst_no_shots", 32'(no_shots_left), 32'b11);
        check("arst_all_empty", 32'(all_empty), 32'd1);
        check("arst_shot_fire", 32'(shot_fire), 32'd0);
        check("arst_hit_count", 32'(hit_count), 32'd0);
        repeat (3) tick();
        Reset_n = 1'b1;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
